// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared constants and the front-end FSM state type for the fetch queue.
//   PC_START  : PC issued after reset
//   INSTR_NOP : instruction presented on inst while the queue is empty
package fetch_queue_pkg;

    localparam logic [31:0] PC_START  = 32'h0000_2000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;   // addi x0, x0, 0

    typedef enum logic {
        ST_RESET,
        ST_RUN
    } fq_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Groups the redirect, memory-side and decode-side signals of the fetch queue.
//   master : the fetch queue (drives fetch_addr/fetch_request and the queue head)
//   slave  : the environment (memory, branch unit, decode)
//   redirect_valid/redirect_pc : jump/branch taken, refetch target
//   fetch_addr/fetch_request/fetch_ready : request handshake
//   fetch_data_valid/request_data        : in-order response
//   inst_valid/inst/inst_pc/inst_ready   : queue head to decode
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_request;
    logic            fetch_ready;
    logic            fetch_data_valid;
    logic [XLEN-1:0] request_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        input  redirect_valid, redirect_pc, fetch_ready, fetch_data_valid,
               request_data, inst_ready,
        output fetch_addr, fetch_request, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, fetch_ready, fetch_data_valid,
               request_data, inst_ready,
        input  fetch_addr, fetch_request, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo
//   Generic synchronous FIFO with flush and asynchronous active-high reset.
//   Head is read combinationally from storage (no bypass: a push into an
//   empty FIFO becomes visible the following cycle).
//   clk, reset          : clock, async reset
//   flush               : discard all entries (dominates push/pop)
//   push, push_data     : write when not full, or when full and popping
//   pop, pop_data       : remove head when not empty; pop_data is the head
//   count               : current occupancy (0..DEPTH)
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, empty, do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Explicit wrap so non-power-of-two depths (e.g. tag FIFO sized by MAX_OUT) work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Decoupled instruction-fetch front end. Issues pipelined in-order fetch
//   requests, tags each with its PC, and buffers returned instructions with
//   their PCs for decode. A redirect flushes the queue and squashes every
//   response still in flight.
//   clk, reset : clock, async active-high reset
//   bus        : fetch_queue_if.master (redirect, memory handshake, decode head)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] START_PC = XLEN'(PC_START)
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int QCW = $clog2(DEPTH) + 1;
    localparam int TCW = $clog2(MAX_OUT) + 1;
    localparam int OW  = $clog2(MAX_OUT + 1);
    localparam int SW  = QCW + 1;

    fq_state_t         state, state_next;
    logic [XLEN-1:0]   fetch_addr;
    logic [OW-1:0]     outstanding, squash, out_next;
    logic              fetch_request, accept, resp, resp_live;
    logic [QCW-1:0]    q_count;
    logic [TCW-1:0]    tag_count;
    logic [2*XLEN-1:0] q_head;
    logic [XLEN-1:0]   tag_head;
    logic [SW-1:0]     in_use;
    logic              inst_valid;

    // Tags hold only live (unsquashed) requests, so tag_count is the live
    // outstanding count: queue space is reserved for every live response.
    assign in_use = SW'(q_count) + SW'(tag_count);

    always_comb begin
        state_next    = state;
        fetch_request = 1'b0;
        case (state)
            ST_RESET: state_next = ST_RUN;
            ST_RUN:   fetch_request = !bus.redirect_valid
                                   && (outstanding < OW'(MAX_OUT))
                                   && (in_use < SW'(DEPTH));
            default:  state_next = ST_RESET;
        endcase
    end

    assign accept    = fetch_request && bus.fetch_ready;
    assign resp      = bus.fetch_data_valid && (outstanding != '0);
    // Squashed responses belong to the flushed epoch: they must not pop a tag,
    // which by now would belong to a request issued after the redirect.
    assign resp_live = resp && (squash == '0) && !bus.redirect_valid;
    assign out_next  = outstanding + OW'(accept) - OW'(resp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RESET;
            fetch_addr  <= START_PC;
            outstanding <= '0;
            squash      <= '0;
        end else begin
            state       <= state_next;
            outstanding <= out_next;
            if (bus.redirect_valid) begin
                fetch_addr <= bus.redirect_pc;
                squash     <= out_next;
            end else begin
                if (accept)                  fetch_addr <= fetch_addr + XLEN'(4);
                if (resp && squash != '0)    squash     <= squash - 1'b1;
            end
        end
    end

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (resp_live),
        .push_data ({bus.request_data, tag_head}),
        .pop       (bus.inst_ready && inst_valid),
        .pop_data  (q_head),
        .count     (q_count)
    );

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (accept),
        .push_data (fetch_addr),
        .pop       (resp_live),
        .pop_data  (tag_head),
        .count     (tag_count)
    );

    assign inst_valid        = (q_count != '0);
    assign bus.inst_valid    = inst_valid;
    assign bus.inst          = inst_valid ? q_head[2*XLEN-1:XLEN] : XLEN'(INSTR_NOP);
    assign bus.inst_pc       = inst_valid ? q_head[XLEN-1:0] : '0;
    assign bus.fetch_addr    = fetch_addr;
    assign bus.fetch_request = fetch_request;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=4, MAX_OUT=2, START_PC=0x2000).
//   A memory responder returns {16'hA5A5, addr[15:0]} after a programmable
//   latency; a monitor logs every instruction decode consumes.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int lat = 1, cyc = 0, out_cnt = 0, max_out = 0, acc_cnt = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data  = '0;
    logic        spur      = 1'b0;
    logic [31:0] mon_pc[$], mon_inst[$];
    int          mon_cyc[$];

    assign bus.fetch_data_valid = mem_valid | spur;
    assign bus.request_data     = spur ? 32'hDEAD_BEEF : mem_data;

    // Memory: samples the handshake at the edge, presents responses 1ns later.
    always @(posedge clk) begin
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            out_cnt = 0;
        end else begin
            if (mem_valid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                out_cnt--;
            end
            if (bus.fetch_request && bus.fetch_ready) begin
                pend_addr.push_back(bus.fetch_addr);
                pend_due.push_back(cyc + lat);
                out_cnt++;
                acc_cnt++;
                if (out_cnt > max_out) max_out = out_cnt;
            end
        end
        cyc++;
        #1;
        if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_valid = 1'b1;
            mem_data  = {16'hA5A5, pend_addr[0][15:0]};
        end else begin
            mem_valid = 1'b0;
            mem_data  = '0;
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.inst_valid && bus.inst_ready) begin
            mon_pc.push_back(bus.inst_pc);
            mon_inst.push_back(bus.inst);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset(input int l, input logic ir, input logic fr);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        spur = 1'b0;
        lat = l;
        bus.inst_ready = ir;
        bus.fetch_ready = fr;
        step(2);
        mon_pc.delete(); mon_inst.delete(); mon_cyc.delete();
        acc_cnt = 0;
        max_out = 0;
        reset = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            ok = (mon_pc.size() >= n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        bus.inst_ready = 1'b1; bus.fetch_ready = 1'b1;
        step(1);
        @(negedge clk);
        n_tests++;
        if ({bus.fetch_request, bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_addr}
            !== {1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h2000}) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%0b iv=%0b inst=%h pc=%h addr=%h want 0 0 00000013 00000000 00002000",
                     bus.fetch_request, bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_addr);
        end
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.fetch_request !== 1'b0) begin
            n_fail++; $display("FAIL release_no_req: req=%0b want 0", bus.fetch_request);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.fetch_request, bus.fetch_addr} !== {1'b1, 32'h2000}) begin
            n_fail++; $display("FAIL first_req: req=%0b addr=%h want 1 00002000", bus.fetch_request, bus.fetch_addr);
        end
    endtask

    task automatic test_stream;
        bit ok;
        logic [31:0] exp_pc [6]   = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010, 32'h2014};
        logic [31:0] exp_inst [6] = '{32'hA5A52000, 32'hA5A52004, 32'hA5A52008,
                                      32'hA5A5200C, 32'hA5A52010, 32'hA5A52014};
        do_reset(1, 1'b1, 1'b1);
        wait_pops(6, 40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stream_timeout: pops=%0d want 6", mon_pc.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if ({mon_pc[i], mon_inst[i]} !== {exp_pc[i], exp_inst[i]}) begin
                    n_fail++;
                    $display("FAIL stream_%0d: pc=%h inst=%h want %h %h", i, mon_pc[i], mon_inst[i], exp_pc[i], exp_inst[i]);
                end
            end
            n_tests++;
            if (mon_cyc[5] - mon_cyc[0] != 5) begin
                n_fail++; $display("FAIL stream_rate: 6 pops over %0d cycles want 5", mon_cyc[5] - mon_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        do_reset(1, 1'b0, 1'b1);
        step(12);
        @(negedge clk);
        n_tests++;
        if ({acc_cnt == 4, bus.fetch_request, bus.inst_valid, bus.inst_pc} !== {1'b1, 1'b0, 1'b1, 32'h2000}) begin
            n_fail++;
            $display("FAIL full_stop: accepts=%0d req=%0b iv=%0b pc=%h want 4 0 1 00002000",
                     acc_cnt, bus.fetch_request, bus.inst_valid, bus.inst_pc);
        end
        @(posedge clk); #2 bus.inst_ready = 1'b1;
        @(posedge clk); #2 bus.inst_ready = 1'b0;
        step(6);
        @(negedge clk);
        n_tests++;
        if ({acc_cnt == 5, bus.fetch_request, mon_pc.size() == 1} !== 3'b101) begin
            n_fail++;
            $display("FAIL pop_one_refill: accepts=%0d req=%0b pops=%0d want 5 0 1", acc_cnt, bus.fetch_request, mon_pc.size());
        end
        @(posedge clk); #2 bus.inst_ready = 1'b1;
        wait_pops(5, 30, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: pops=%0d want 5", mon_pc.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (mon_pc[i] !== 32'h2000 + 32'(4 * i)) begin
                    n_fail++; $display("FAIL bp_order_%0d: pc=%h want %h", i, mon_pc[i], 32'h2000 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_latency;
        bit ok;
        do_reset(3, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.fetch_request, bus.fetch_addr} !== {1'b1, 32'h2000}) begin
                n_fail++; $display("FAIL hold_addr_%0d: req=%0b addr=%h want 1 00002000", i, bus.fetch_request, bus.fetch_addr);
            end
        end
        @(posedge clk); #2 bus.fetch_ready = 1'b1;
        wait_pops(6, 60, ok);
        n_tests++;
        if (max_out !== 2) begin n_fail++; $display("FAIL max_outstanding: got %0d want 2", max_out); end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL lat_timeout: pops=%0d want 6", mon_pc.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (mon_pc[i] !== 32'h2000 + 32'(4 * i)) begin
                    n_fail++; $display("FAIL lat_order_%0d: pc=%h want %h", i, mon_pc[i], 32'h2000 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect;
        bit ok = 1'b0;
        do_reset(3, 1'b0, 1'b1);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (out_cnt == 2) && bus.inst_valid;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL redir_setup: outstanding=%0d iv=%0b want 2 1", out_cnt, bus.inst_valid); end
        bus.redirect_pc = 32'h3000; bus.redirect_valid = 1'b1;
        mon_pc.delete(); mon_inst.delete(); mon_cyc.delete();
        @(posedge clk); #2 bus.redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.inst_valid, bus.inst, bus.fetch_addr, bus.fetch_request} !== {1'b0, 32'h13, 32'h3000, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_flush: iv=%0b inst=%h addr=%h req=%0b want 0 00000013 00003000 0",
                     bus.inst_valid, bus.inst, bus.fetch_addr, bus.fetch_request);
        end
        @(posedge clk); #2 bus.inst_ready = 1'b1;
        wait_pops(2, 40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL redir_timeout: pops=%0d want 2", mon_pc.size()); end
        else begin
            n_tests++;
            if ({mon_pc[0], mon_inst[0], mon_pc[1]} !== {32'h3000, 32'hA5A53000, 32'h3004}) begin
                n_fail++;
                $display("FAIL redir_target: pc0=%h inst0=%h pc1=%h want 00003000 a5a53000 00003004",
                         mon_pc[0], mon_inst[0], mon_pc[1]);
            end
        end
    endtask

    task automatic test_collision;
        bit ok;
        do_reset(1, 1'b1, 1'b1);
        step(8);
        @(negedge clk); #1;
        n_tests++;
        if ({bus.fetch_data_valid, bus.inst_valid} !== 2'b11) begin
            n_fail++; $display("FAIL coll_setup: resp=%0b iv=%0b want 1 1", bus.fetch_data_valid, bus.inst_valid);
        end
        bus.redirect_pc = 32'h4000; bus.redirect_valid = 1'b1;
        mon_pc.delete(); mon_inst.delete(); mon_cyc.delete();
        @(posedge clk); #2 bus.redirect_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.inst_valid, bus.fetch_request, bus.fetch_addr} !== {1'b0, 1'b1, 32'h4000}) begin
            n_fail++;
            $display("FAIL coll_drop: iv=%0b req=%0b addr=%h want 0 1 00004000", bus.inst_valid, bus.fetch_request, bus.fetch_addr);
        end
        wait_pops(2, 30, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL coll_timeout: pops=%0d want 2", mon_pc.size()); end
        else begin
            n_tests++;
            if ({mon_pc[0], mon_inst[0], mon_pc[1]} !== {32'h4000, 32'hA5A54000, 32'h4004}) begin
                n_fail++;
                $display("FAIL coll_target: pc0=%h inst0=%h pc1=%h want 00004000 a5a54000 00004004",
                         mon_pc[0], mon_inst[0], mon_pc[1]);
            end
        end
    endtask

    task automatic test_spurious;
        bit ok;
        do_reset(1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.fetch_request, bus.inst_valid} !== 2'b10) begin
            n_fail++; $display("FAIL spur_setup: req=%0b iv=%0b want 1 0", bus.fetch_request, bus.inst_valid);
        end
        @(posedge clk); #2 spur = 1'b1;
        @(posedge clk); #2 spur = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.fetch_request, bus.inst_valid} !== 2'b10) begin
            n_fail++; $display("FAIL spur_ignored: req=%0b iv=%0b want 1 0", bus.fetch_request, bus.inst_valid);
        end
        @(posedge clk); #2 bus.fetch_ready = 1'b1;
        wait_pops(1, 20, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL spur_timeout: pops=%0d want 1", mon_pc.size()); end
        else begin
            n_tests++;
            if ({mon_pc[0], mon_inst[0]} !== {32'h2000, 32'hA5A52000}) begin
                n_fail++; $display("FAIL spur_first: pc=%h inst=%h want 00002000 a5a52000", mon_pc[0], mon_inst[0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b0;
        do_reset(3, 1'b0, 1'b1);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (out_cnt == 2) && bus.inst_valid;
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mid_setup: outstanding=%0d iv=%0b want 2 1", out_cnt, bus.inst_valid); end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.fetch_request, bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_addr}
            !== {1'b0, 1'b0, 32'h0000_0013, 32'h0, 32'h2000}) begin
            n_fail++;
            $display("FAIL mid_reset: req=%0b iv=%0b inst=%h pc=%h addr=%h want 0 0 00000013 00000000 00002000",
                     bus.fetch_request, bus.inst_valid, bus.inst, bus.inst_pc, bus.fetch_addr);
        end
        @(posedge clk); #2;
        mon_pc.delete(); mon_inst.delete(); mon_cyc.delete();
        reset = 1'b0;
        bus.inst_ready = 1'b1;
        wait_pops(2, 40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mid_timeout: pops=%0d want 2", mon_pc.size()); end
        else begin
            n_tests++;
            if ({mon_pc[0], mon_inst[0], mon_pc[1]} !== {32'h2000, 32'hA5A52000, 32'h2004}) begin
                n_fail++;
                $display("FAIL mid_restart: pc0=%h inst0=%h pc1=%h want 00002000 a5a52000 00002004",
                         mon_pc[0], mon_inst[0], mon_pc[1]);
            end
        end
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.fetch_ready    = 1'b0;
        bus.inst_ready     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_redirect();
        test_collision();
        test_spurious();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
